fls_chk: RTL and testbench
==========================

Name: fls_chk

Overview:
- Receiving end of the Fibonacci-like sequence (FLS) stream produced by the team's fls generator.
- Accepts one term per enable strobe and captures the two seed terms.
- Checks every later term against the recurrence f[n] = f[n-1] + f[n-2], counts accepted terms and flags mismatch or arithmetic overflow.
- Sits downstream of the generator on the board or bench; its outputs drive LEDs or the self-check.

Parameters:
- W, 8: term width in bits; must equal the generator's data width.
- CNT_W, 8: width of the accepted-term counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear. Returns the block to IDLE. Takes priority over en.
- en  input  1  term-valid strobe; d is sampled on a rising edge only when en=1.
- d  input  W  incoming sequence term.
- seed_a  output  W  first term received.
- seed_b  output  W  second term received.
- exp  output  W  expected next term (p1+p2, low W bits) while in CHECK; 0 in all other states.
- cnt  output  CNT_W  number of terms accepted, saturating.
- match  output  1  one-cycle pulse: the last sampled term satisfied the recurrence.
- err  output  1  sticky: a term mismatched the recurrence.
- ovf  output  1  sticky: the expected sum exceeded W bits.

Behaviour:
- Reset (rstn=0, asynchronous, no clock needed):
  - state=IDLE.
  - seed_a, seed_b, exp, cnt, match, err, ovf all 0.
  - Internal history registers p1 and p2 = 0.
- All outputs are registered.
- Each sampled term updates outputs on the same edge where en=1 is seen, so the response is visible in the following cycle.
- match defaults to 0 every cycle and is high only for the cycle after an accepted recurrence check.
- States: IDLE, GOT1, CHECK, FAIL (2-bit encoding).
- IDLE, en=1: seed_a<=d, p1<=d, cnt<=1, go to GOT1.
- GOT1, en=1: seed_b<=d, p2<=p1, p1<=d, cnt<=2, go to CHECK.
- CHECK, en=1: compute sum = p1 + p2 at W+1 bits.
  - sum[W]=1: ovf<=1, go to FAIL. d is not compared and cnt is unchanged.
  - Else if d == sum[W-1:0]: match<=1, p2<=p1, p1<=d, cnt<=cnt+1 (saturates at 2^CNT_W-1), stay in CHECK.
  - Else: err<=1, go to FAIL. cnt is unchanged.
- FAIL: en is ignored. seed_a, seed_b, cnt, err and ovf hold. exp=0. Exit only via clr or rstn.
- en=0 in any state: nothing changes except match returning to 0. d is don't-care.
- clr=1 on an edge: same values as reset, state=IDLE. A simultaneous en is discarded.
- Overflow is checked before equality. A wrapped sum is never reported as a match, even if d equals the low W bits.
- Seed values are unrestricted, including 0 and 2^W-1.
- No output is ever X after reset.

Test Plan:
- Normal stream 1,1,2,3,5,8,13 on consecutive en cycles:
  - seed_a=1, seed_b=1, cnt=7.
  - match pulses exactly 5 times.
  - err=0, ovf=0, exp=21 at end.
- Mismatch 3,4,7,12:
  - After 12: err=1, state FAIL, cnt=3, exp=0.
  - A further en with d=19 changes nothing.
  - clr=1 for one cycle: all outputs 0.
  - Then 5,5,10 gives cnt=3 and err=0.
- Overflow 144,233,x with x=121 (the low bits of 377):
  - ovf=1, err=0, match never asserted, cnt=2.
- Gapped enable: en pulses carrying 2, 2, 4, separated by 3 idle cycles in which d toggles randomly with en=0:
  - cnt=3, one match pulse, random d ignored.
- Asynchronous reset mid-stream: after 1,1,2, drop rstn between clock edges.
  - All outputs read 0 before the next edge.
  - After release, 7,7,14 gives seed_a=7, cnt=3.
- Saturation with CNT_W=4: stream of 20 zeros.
  - cnt=15, match pulses 18 times, err=0.

Source files
------------

// File: rtl/fls_chk_if.sv
// fls_chk_if: term stream into the FLS checker and its registered status back out.
interface fls_chk_if #(
  parameter int W     = 8,
  parameter int CNT_W = 8
);
  logic             clr;
  logic             en;
  logic [W-1:0]     d;
  logic [W-1:0]     seed_a;
  logic [W-1:0]     seed_b;
  logic [W-1:0]     exp;
  logic [CNT_W-1:0] cnt;
  logic             match;
  logic             err;
  logic             ovf;
  modport master (output clr, en, d, input seed_a, seed_b, exp, cnt, match, err, ovf);
  modport slave  (input clr, en, d, output seed_a, seed_b, exp, cnt, match, err, ovf);
endinterface

// File: rtl/fls_chk.sv
// fls_chk: captures two seed terms, then checks each term against f[n] = f[n-1] + f[n-2].
module fls_chk #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rstn,
  fls_chk_if.slave   b
);
  typedef enum logic [1:0] {IDLE, GOT1, CHECK, FAIL} state_t;
  state_t           state_q;
  logic [W-1:0]     p1_q, p2_q, seed_a_q, seed_b_q, exp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             match_q, err_q, ovf_q;
  logic [W:0]       sum;
  logic [W-1:0]     nxt;
  assign sum = {1'b0, p1_q} + {1'b0, p2_q};
  // expected term after accepting d: d plus the current newest term
  assign nxt = b.d + p1_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      seed_a_q <= '0;
      seed_b_q <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (b.clr) begin
      state_q  <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      seed_a_q <= '0;
      seed_b_q <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (b.en) begin
        case (state_q)
          IDLE: begin
            seed_a_q <= b.d;
            p1_q     <= b.d;
            cnt_q    <= CNT_W'(1);
            state_q  <= GOT1;
          end
          GOT1: begin
            seed_b_q <= b.d;
            p2_q     <= p1_q;
            p1_q     <= b.d;
            cnt_q    <= CNT_W'(2);
            exp_q    <= nxt;
            state_q  <= CHECK;
          end
          CHECK: begin
            // overflow wins over equality so a wrapped sum never matches
            if (sum[W]) begin
              ovf_q   <= 1'b1;
              exp_q   <= '0;
              state_q <= FAIL;
            end else if (b.d == sum[W-1:0]) begin
              match_q <= 1'b1;
              p2_q    <= p1_q;
              p1_q    <= b.d;
              cnt_q   <= &cnt_q ? cnt_q : cnt_q + 1'b1;
              exp_q   <= nxt;
            end else begin
              err_q   <= 1'b1;
              exp_q   <= '0;
              state_q <= FAIL;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign b.seed_a = seed_a_q;
  assign b.seed_b = seed_b_q;
  assign b.exp    = exp_q;
  assign b.cnt    = cnt_q;
  assign b.match  = match_q;
  assign b.err    = err_q;
  assign b.ovf    = ovf_q;
endmodule

// File: tb/tb_fls_chk.sv
// tb_fls_chk: directed streams against fls_chk (CNT_W=8) and a CNT_W=4 copy for saturation.
module tb_fls_chk;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   mcnt = 0;
  int   mcnt4 = 0;
  fls_chk_if #(.W(8), .CNT_W(8)) b ();
  fls_chk_if #(.W(8), .CNT_W(4)) b4 ();
  fls_chk #(.W(8), .CNT_W(8)) dut (.clk(clk), .rstn(rstn), .b(b));
  fls_chk #(.W(8), .CNT_W(4)) dut4 (.clk(clk), .rstn(rstn), .b(b4));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic put(input logic [7:0] v);
    b.en = 1'b1;
    b.d  = v;
    @(posedge clk);
    #1;
    b.en = 1'b0;
    if (b.match) mcnt++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      b.d = 8'($urandom);
      @(posedge clk);
      #1;
      if (b.match) mcnt++;
    end
  endtask
  task automatic clear();
    b.clr = 1'b1;
    @(posedge clk);
    #1;
    b.clr = 1'b0;
    mcnt = 0;
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_seed_a"}, b.seed_a, 0);
    check({tag, "_seed_b"}, b.seed_b, 0);
    check({tag, "_exp"}, b.exp, 0);
    check({tag, "_cnt"}, b.cnt, 0);
    check({tag, "_match"}, b.match, 0);
    check({tag, "_err"}, b.err, 0);
    check({tag, "_ovf"}, b.ovf, 0);
  endtask
  initial begin
    b.clr = 1'b0; b.en = 1'b0; b.d = '0;
    b4.clr = 1'b0; b4.en = 1'b0; b4.d = '0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    check("reset_cnt4", b4.cnt, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // normal stream
    put(1); put(1); put(2); put(3); put(5); put(8); put(13);
    check("norm_seed_a", b.seed_a, 1);
    check("norm_seed_b", b.seed_b, 1);
    check("norm_cnt", b.cnt, 7);
    check("norm_err", b.err, 0);
    check("norm_ovf", b.ovf, 0);
    check("norm_exp", b.exp, 21);
    idle(1);
    check("norm_match_n", mcnt, 5);
    // mismatch then FAIL lock-up then clr
    clear();
    put(3); put(4);
    check("mis_exp_got2", b.exp, 7);
    put(7); put(12);
    check("mis_err", b.err, 1);
    check("mis_cnt", b.cnt, 3);
    check("mis_exp", b.exp, 0);
    check("mis_match", b.match, 0);
    put(19);
    check("fail_hold_cnt", b.cnt, 3);
    check("fail_hold_err", b.err, 1);
    check("fail_hold_exp", b.exp, 0);
    check("fail_hold_seed_b", b.seed_b, 4);
    clear();
    all_zero("clr");
    put(5); put(5); put(10);
    check("after_clr_cnt", b.cnt, 3);
    check("after_clr_err", b.err, 0);
    check("after_clr_exp", b.exp, 15);
    // overflow: 144+233=377, low bits 121 must not match
    clear();
    put(144); put(233); put(121);
    check("ovf_ovf", b.ovf, 1);
    check("ovf_err", b.err, 0);
    check("ovf_cnt", b.cnt, 2);
    check("ovf_exp", b.exp, 0);
    check("ovf_seed_b", b.seed_b, 233);
    idle(1);
    check("ovf_match_n", mcnt, 0);
    // gapped enable with random d in the gaps
    clear();
    put(2); idle(3); put(2); idle(3); put(4); idle(3);
    check("gap_cnt", b.cnt, 3);
    check("gap_match_n", mcnt, 1);
    check("gap_exp", b.exp, 6);
    check("gap_err", b.err, 0);
    // asynchronous reset between edges
    clear();
    put(1); put(1); put(2);
    #2 rstn = 1'b0;
    #1;
    all_zero("areset");
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    put(7); put(7); put(14);
    check("areset_seed_a", b.seed_a, 7);
    check("areset_cnt", b.cnt, 3);
    check("areset_match", b.match, 1);
    // saturation on the CNT_W=4 instance: 20 zeros
    for (int i = 0; i < 20; i++) begin
      b4.en = 1'b1;
      b4.d  = 8'd0;
      @(posedge clk);
      #1;
      if (b4.match) mcnt4++;
    end
    b4.en = 1'b0;
    @(posedge clk);
    #1;
    if (b4.match) mcnt4++;
    check("sat_cnt", b4.cnt, 15);
    check("sat_match_n", mcnt4, 18);
    check("sat_err", b4.err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
